// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the data word type.
// Imported by the FIFO RTL and the verification components so widths stay consistent.
package fifo_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned PTR_W          = $clog2(DEF_FIFO_DEPTH);
  localparam int unsigned CNT_W          = PTR_W + 1;

  typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

endpackage : fifo_pkg

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with registered read data and handshake status.
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - asynchronous active-high reset
//   wr_en       - write request
//   rd_en       - read request
//   data_in     - write data
//   data_out    - registered read data (1-cycle read latency, holds when no read)
//   wr_ack      - registered: previous-cycle write accepted
//   overflow    - registered: previous-cycle write rejected, FIFO was full
//   underflow   - registered: previous-cycle read rejected, FIFO was empty
//   full        - combinational: count == FIFO_DEPTH
//   almostfull  - combinational: count == FIFO_DEPTH-1
//   empty       - combinational: count == 0
//   almostempty - combinational: count == 1
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH   // power of two, >= 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags are decoded from the occupancy count only.
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == CW'(0));
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count == CW'(FIFO_DEPTH - 1));
  assign almostempty = (r_count == CW'(1));

  // When full a simultaneous read still drains, when empty a simultaneous write still fills.
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  // Storage array: not reset, only written on accepted writes.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Write side: pointer (wraps naturally, depth is a power of two) and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      wr_ack   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ack   <= w_wr_acc;
      overflow <= wr_en && w_full;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
    end
  end

  // Read side: pointer, registered data and underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      data_out  <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= rd_en && w_empty;
      if (w_rd_acc) begin
        data_out <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: moves only when exactly one side is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Synchronous single-clock FIFO. It buffers write-side data words and presents them to the read side in order.
- Status and handshake flags: full/empty, almostfull/almostempty, wr_ack, overflow, underflow.
- Sits directly upstream of the FIFO monitor/scoreboard, which samples every output 1 time unit after each rising clk edge.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of storage entries; power of two, >= 4.
- Derived (localparam): PTR_W = $clog2(FIFO_DEPTH); count width = PTR_W+1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_in  input  FIFO_WIDTH  write data.
- data_out  output  FIFO_WIDTH  registered read data.
- wr_ack  output  1  registered; previous-cycle write accepted.
- overflow  output  1  registered; previous-cycle write rejected because the FIFO was full.
- underflow  output  1  registered; previous-cycle read rejected because the FIFO was empty.
- full  output  1  combinational, count == FIFO_DEPTH.
- almostfull  output  1  combinational, count == FIFO_DEPTH-1.
- empty  output  1  combinational, count == 0.
- almostempty  output  1  combinational, count == 1.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (rst=1, asynchronous):
  - wr_ptr, rd_ptr and count are cleared to 0.
  - data_out, wr_ack, overflow and underflow are cleared to 0.
  - Flags follow immediately: empty=1, others 0.
  - Memory contents are not cleared.
- Reset mid-operation: all buffered words are discarded. The first write after rst deasserts is the first word read.
- Write accept: wr_en && !full.
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments, wrapping FIFO_DEPTH-1 -> 0.
  - wr_ack <= 1.
- Write reject: wr_en && full. Memory and wr_ptr are unchanged; overflow <= 1, wr_ack <= 0.
- No write request: wr_ack <= 0 and overflow <= 0.
- Read accept: rd_en && !empty.
  - data_out <= mem[rd_ptr]; read latency is 1 cycle.
  - rd_ptr increments and wraps.
  - underflow <= 0.
- Read reject: rd_en && empty. data_out holds its value; underflow <= 1.
- No read request: underflow <= 0 and data_out holds.
- Count update:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous wr_en && rd_en:
  - When full: read accepted, write rejected (overflow=1, wr_ack=0); count goes DEPTH -> DEPTH-1.
  - When empty: write accepted (wr_ack=1), read rejected (underflow=1); count goes 0 -> 1.
  - Otherwise both are accepted and count is unchanged.
- Flags are decoded from count only, never from pointer comparison.
- count never exceeds FIFO_DEPTH and never goes below 0.

Decomposition:
- Shared package (fifo_pkg):
  - FIFO_WIDTH/FIFO_DEPTH defaults.
  - typedef logic [FIFO_WIDTH-1:0] fifo_word_t.
  - PTR_W localparam.
  - The monitor, scoreboard and coverage classes import the same package so widths stay consistent.
- No sub-module: memory, pointers, count and flag decode fit in one module. A separate fifo_mem is not warranted.

Test Plan:
- Reset check: assert rst for 2 cycles then release -> empty=1, full=0, almostempty=0, wr_ack=0, overflow=0, underflow=0, data_out=0.
- Fill and order:
  - Write 0x0001..0x0008 on consecutive cycles.
  - After the 7th write almostfull=1; after the 8th full=1; wr_ack=1 each cycle.
  - A 9th write gives overflow=1, wr_ack=0.
  - Then read 8 times -> data_out = 0x0001..0x0008 in order, each 1 cycle after rd_en.
  - almostempty=1 when one word remains; empty=1 at the end.
- Underflow: with the FIFO empty, rd_en=1 for 1 cycle -> underflow=1 next cycle, data_out unchanged, count stays 0.
- Simultaneous access:
  - Full FIFO with wr_en=rd_en=1 -> overflow=1, oldest word read, full deasserts.
  - Empty FIFO with wr_en=rd_en=1 -> wr_ack=1, underflow=1, count=1.
  - With count=4 -> wr_ack=1, count stays 4.
- Wrap-around: 20 cycles of interleaved write/read with count held at 3 → pointers wrap at least twice; every word matches the scoreboard reference queue.
- Reset mid-operation:
  - Write 5 words, assert rst asynchronously between clock edges -> all flags/outputs reset immediately, empty=1.
  - Next write 0xABCD, then read -> data_out=0xABCD.
